// File: rtl/regfile_mp.sv
// Multi-read-port register file for the pipelined MIPS datapath: one synchronous write
// port, NUM_RD registered write-first read ports, and a per-register busy scoreboard.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic                     ctrl_writeEnable,
    input  logic [ADDR_W-1:0]        ctrl_writeReg,
    input  logic [DATA_W-1:0]        data_writeReg,
    input  logic                     ctrl_reserve,
    input  logic [ADDR_W-1:0]        ctrl_reserveReg,
    input  logic [NUM_RD-1:0]        ctrl_readEnable,
    input  logic [NUM_RD*ADDR_W-1:0] ctrl_readReg,
    output logic [NUM_RD*DATA_W-1:0] data_readReg,
    output logic [NUM_RD-1:0]        read_valid,
    output logic [NUM_RD-1:0]        reg_busy
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0]        mem_q [NUM_REGS];
    logic [DATA_W-1:0]        mem_d [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
    logic                     wr_ok, rsv_ok;

    // Register 0 never changes when hardwired, so reset alone keeps it zero and idle.
    assign wr_ok  = ctrl_writeEnable && !((ZERO_REG != 0) && (ctrl_writeReg == '0));
    assign rsv_ok = ctrl_reserve && !((ZERO_REG != 0) && (ctrl_reserveReg == '0));

    // read_valid[i] is a one-cycle strobe: high exactly in the cycle after an edge at which
    // ctrl_readEnable[i] was high; data_readReg/reg_busy for port i are meaningful then and
    // hold unchanged while the port is idle. There is no back-pressure.
    always_comb begin
        mem_d      = mem_q;
        busy_d     = busy_q;
        rd_data_d  = rd_data_q;
        rd_busy_d  = rd_busy_q;
        rd_valid_d = '0;
        if (wr_ok) begin
            mem_d[ctrl_writeReg]  = data_writeReg;
            busy_d[ctrl_writeReg] = 1'b0;
        end
        // A reserve applied after the write lets the newer producer win.
        if (rsv_ok) begin
            busy_d[ctrl_reserveReg] = 1'b1;
        end
        // Reads sample the post-update state, which gives write-first bypass.
        for (int i = 0; i < NUM_RD; i++) begin
            if (ctrl_readEnable[i]) begin
                rd_data_d[i*DATA_W +: DATA_W] = mem_d[ctrl_readReg[i*ADDR_W +: ADDR_W]];
                rd_busy_d[i]                  = busy_d[ctrl_readReg[i*ADDR_W +: ADDR_W]];
                rd_valid_d[i]                 = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= '0;
            end
            busy_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            rd_busy_q  <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_busy_q  <= rd_busy_d;
        end
    end

    assign data_readReg = rd_data_q;
    assign read_valid   = rd_valid_q;
    assign reg_busy     = rd_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, a hand-written hold sequence, and random
// traffic scored against an array-based model of the register file.
module tb_regfile_mp;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        ctrl_reserve;
    logic [4:0]  ctrl_reserveReg;
    logic [1:0]  ctrl_readEnable;
    logic [9:0]  ctrl_readReg;
    logic [63:0] data_readReg;
    logic [1:0]  read_valid;
    logic [1:0]  reg_busy;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_reserve     (ctrl_reserve),
        .ctrl_reserveReg  (ctrl_reserveReg),
        .ctrl_readEnable  (ctrl_readEnable),
        .ctrl_readReg     (ctrl_readReg),
        .data_readReg     (data_readReg),
        .read_valid       (read_valid),
        .reg_busy         (reg_busy)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: plain arrays, updated by the rules of one clock edge
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    logic [31:0] m_d [2];
    bit          m_v [2];
    bit          m_b [2];
    bit          scoring = 0;
    logic [67:0] exp_q[$];

    task automatic model_edge(input logic rst, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic rsv, input logic [4:0] rr,
                              input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1);
        logic [4:0] ra [2];
        ra[0] = ra0;
        ra[1] = ra1;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r]  = 32'h0;
                m_busy[r] = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                m_d[i] = 32'h0;
                m_v[i] = 1'b0;
                m_b[i] = 1'b0;
            end
        end else begin
            if (we && wa != 5'd0) begin
                m_mem[wa]  = wd;
                m_busy[wa] = 1'b0;
            end
            if (rsv && rr != 5'd0) m_busy[rr] = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_v[i] = re[i];
                if (re[i]) begin
                    m_d[i] = m_mem[ra[i]];
                    m_b[i] = m_busy[ra[i]];
                end
            end
        end
        if (scoring) exp_q.push_back({m_b[1], m_b[0], m_v[1], m_v[0], m_d[1], m_d[0]});
    endtask

    // driver: present one cycle of inputs, clock it, settle past the edge
    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic rsv, input logic [4:0] rr,
                         input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1);
        ctrl_reset       = rst;
        ctrl_writeEnable = we;
        ctrl_writeReg    = wa;
        data_writeReg    = wd;
        ctrl_reserve     = rsv;
        ctrl_reserveReg  = rr;
        ctrl_readEnable  = re;
        ctrl_readReg     = {ra1, ra0};
        model_edge(rst, we, wa, wd, rsv, rr, re, ra0, ra1);
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        rst, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rsv;
        logic [4:0]  rr;
        logic [1:0]  re;
        logic [4:0]  ra0, ra1;
        logic [31:0] e_d0, e_d1;
        logic [1:0]  e_v, e_b;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic rst, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd, input logic rsv,
                                input logic [4:0] rr, input logic [1:0] re, input logic [4:0] ra0,
                                input logic [4:0] ra1, input logic [31:0] e_d0,
                                input logic [31:0] e_d1, input logic [1:0] e_v, input logic [1:0] e_b);
        vec_t v;
        v.name = name; v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.rsv = rsv; v.rr = rr;
        v.re = re; v.ra0 = ra0; v.ra1 = ra1; v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_v = e_v; v.e_b = e_b;
        return v;
    endfunction

    initial begin
        //                 name            rst we wa  wd            rsv rr  re     ra0 ra1  d0            d1            v      b
        vecs.push_back(mk("reset_state",   1, 0, 0,  32'h0,        0, 0,  2'b00, 0,  0,  32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("wr_r5",         0, 1, 5,  32'hDEADBEEF, 0, 0,  2'b00, 0,  0,  32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("reset_again",   1, 0, 0,  32'h0,        0, 0,  2'b00, 0,  0,  32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("rd_r5_cleared", 0, 0, 0,  32'h0,        0, 0,  2'b01, 5,  0,  32'h0,        32'h0,        2'b01, 2'b00));
        vecs.push_back(mk("wr_r7",         0, 1, 7,  32'h12345678, 0, 0,  2'b00, 0,  0,  32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("rd_r7_both",    0, 0, 0,  32'h0,        0, 0,  2'b11, 7,  7,  32'h12345678, 32'h12345678, 2'b11, 2'b00));
        vecs.push_back(mk("bypass_r3",     0, 1, 3,  32'hCAFEF00D, 0, 0,  2'b10, 0,  3,  32'h12345678, 32'hCAFEF00D, 2'b10, 2'b00));
        vecs.push_back(mk("wr_rsv_r0",     0, 1, 0,  32'hFFFFFFFF, 1, 0,  2'b00, 0,  0,  32'h12345678, 32'hCAFEF00D, 2'b00, 2'b00));
        vecs.push_back(mk("rd_r0",         0, 0, 0,  32'h0,        0, 0,  2'b01, 0,  0,  32'h0,        32'hCAFEF00D, 2'b01, 2'b00));
        vecs.push_back(mk("rsv_r9",        0, 0, 0,  32'h0,        1, 9,  2'b00, 0,  0,  32'h0,        32'hCAFEF00D, 2'b00, 2'b00));
        vecs.push_back(mk("rd_r9_busy",    0, 0, 0,  32'h0,        0, 0,  2'b01, 9,  0,  32'h0,        32'hCAFEF00D, 2'b01, 2'b01));
        vecs.push_back(mk("wr_rsv_r9",     0, 1, 9,  32'h42,       1, 9,  2'b00, 0,  0,  32'h0,        32'hCAFEF00D, 2'b00, 2'b01));
        vecs.push_back(mk("rd_r9_still",   0, 0, 0,  32'h0,        0, 0,  2'b01, 9,  0,  32'h42,       32'hCAFEF00D, 2'b01, 2'b01));
        vecs.push_back(mk("wr_r9_plain",   0, 1, 9,  32'h42,       0, 0,  2'b00, 0,  0,  32'h42,       32'hCAFEF00D, 2'b00, 2'b01));
        vecs.push_back(mk("rd_r9_free",    0, 0, 0,  32'h0,        0, 0,  2'b11, 9,  9,  32'h42,       32'h42,       2'b11, 2'b00));
        vecs.push_back(mk("byp_wr_rsv_r9", 0, 1, 9,  32'h77,       1, 9,  2'b01, 9,  0,  32'h77,       32'h42,       2'b01, 2'b01));
        vecs.push_back(mk("rd_r9_r3",      0, 0, 0,  32'h0,        0, 0,  2'b11, 3,  9,  32'hCAFEF00D, 32'h77,       2'b11, 2'b10));
        vecs.push_back(mk("reset_discard", 1, 1, 4,  32'hAAAA5555, 1, 4,  2'b11, 4,  4,  32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("rd_r4_r3",      0, 0, 0,  32'h0,        0, 0,  2'b11, 4,  3,  32'h0,        32'h0,        2'b11, 2'b00));

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].rsv, vecs[k].rr,
                  vecs[k].re, vecs[k].ra0, vecs[k].ra1);
            check({vecs[k].name, ".d0"}, {36'h0, data_readReg[31:0]}, {36'h0, vecs[k].e_d0});
            check({vecs[k].name, ".d1"}, {36'h0, data_readReg[63:32]}, {36'h0, vecs[k].e_d1});
            check({vecs[k].name, ".valid"}, {66'h0, read_valid}, {66'h0, vecs[k].e_v});
            check({vecs[k].name, ".busy"}, {66'h0, reg_busy}, {66'h0, vecs[k].e_b});
        end

        // hold while idle: port 0 keeps its last capture over three cycles of writes
        drive(0, 1, 7, 32'h12345678, 0, 0, 2'b00, 0, 0);
        drive(0, 0, 0, 32'h0, 1, 7, 2'b01, 7, 0);
        check("hold.first_d0", {36'h0, data_readReg[31:0]}, {36'h0, 32'h12345678});
        check("hold.first_busy", {66'h0, reg_busy}, {66'h0, 2'b01});
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 7, 32'h1, 0, 0, 2'b00, 0, 0);
            check("hold.d0", {36'h0, data_readReg[31:0]}, {36'h0, 32'h12345678});
            check("hold.valid", {66'h0, read_valid}, {66'h0, 2'b00});
            check("hold.busy", {66'h0, reg_busy}, {66'h0, 2'b01});
        end
        drive(0, 0, 0, 32'h0, 0, 0, 2'b01, 7, 0);
        check("hold.reread_d0", {36'h0, data_readReg[31:0]}, {36'h0, 32'h1});
        check("hold.reread_busy", {66'h0, reg_busy}, {66'h0, 2'b00});

        // random traffic against the model; narrow address range forces collisions
        scoring = 1;
        for (int n = 0; n < 3000; n++) begin
            logic [4:0]  wa, rr, ra0, ra1;
            logic [67:0] exp;
            bit          wide;
            wide = ($urandom_range(0, 3) == 0);
            wa   = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rr   = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ra0  = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ra1  = ($urandom_range(0, 3) == 0) ? ra0 : 5'($urandom_range(0, 7));
            drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), wa, $urandom,
                  1'($urandom_range(0, 1)), rr, 2'($urandom_range(0, 3)), ra0, ra1);
            exp = exp_q.pop_front();
            check("random", {reg_busy, read_valid, data_readReg}, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
